// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with shift-add multiply, status flags and valid/ready handshakes
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      request handshake; opcode, a, b sampled on accept
//   out_valid/out_ready    result handshake; results and flags held until transfer
//   res_lo, res_hi         2*WIDTH-bit result, high half 0 for single-width ops
//   flag_zero/carry/err    result zero, ADD carry or SUB borrow, illegal opcode
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_err
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-2:0] ZP = '0;
  localparam logic [WIDTH-1:0] ZW = '0;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [W2-1:0]    res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_lo, alu_hi;
  logic             alu_carry, alu_err;
  logic [W2-1:0]    acc_next;
  logic             accept, out_fire;

  // rst_n is folded in so nothing is accepted while reset is held.
  assign in_ready = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign res_lo     = res_q[WIDTH-1:0];
  assign res_hi     = res_q[W2-1:WIDTH];
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_err   = err_q;

  // Single-cycle operations; MUL (16) is handled by the FSM.
  always_comb begin
    alu_lo    = '0;
    alu_hi    = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (opcode)
      5'd0:  alu_lo = {ZP, |a};
      5'd1:  alu_lo = {ZP, ^a};
      5'd2:  alu_lo = {ZP, &a};
      5'd3:  alu_lo = {ZP, a == ZW};
      5'd4:  alu_lo = ~a;
      5'd5:  alu_lo = {ZP, b == ZW};
      5'd6:  alu_lo = ~b;
      5'd7:  alu_lo = {ZP, &b};
      5'd8:  alu_lo = a & b;
      5'd9:  alu_lo = a | b;
      5'd10: alu_lo = a ^ b;
      5'd11: alu_lo = {ZP, a > b};
      5'd12: alu_lo = {ZP, a < b};
      5'd13: alu_lo = {ZP, a == b};
      5'd14: begin
        {alu_hi, alu_lo} = {ZW, a} + {ZW, b};
        alu_carry        = alu_hi[0];
      end
      5'd15: begin
        // Double-width subtract: a borrow sign-fills the high half.
        {alu_hi, alu_lo} = {ZW, a} - {ZW, b};
        alu_carry        = a < b;
      end
      5'd16: ;
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    err_d       = err_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == 5'd16) begin
            mcand_d     = {ZW, a};
            mplier_d    = b;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = MUL;
          end else begin
            res_d       = {alu_hi, alu_lo};
            zero_d      = ({alu_hi, alu_lo} == '0);
            carry_d     = alu_carry;
            err_d       = alu_err;
            out_valid_d = 1'b1;
          end
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end
      end
      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_d       = acc_next;
          zero_d      = (acc_next == '0);
          carry_d     = 1'b0;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      err_q       <= err_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
